// File: rtl/roller_pkg.sv
// roller_pkg
// Shared definitions for the roller controller: FSM state encoding, display
// geometry, the roller's initial positions and the anode decode helper.
package roller_pkg;

    // 2'd3 is not a legal state; the controller recovers from it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;

    // Roller positions after pos_clr, digit 0 in the low bits: 0,1,2,3.
    localparam logic [7:0] POS_INIT = {2'd3, 2'd2, 2'd1, 2'd0};

    // Active-low one-hot anode pattern for the selected digit.
    function automatic logic [NUM_DIGITS-1:0] an_from_idx(input logic [1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/roller_debounce.sv
// roller_debounce
// Conditions one raw asynchronous push-button: 2-flop synchronizer, stability
// counter and rising-edge detector.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   raw   - raw button input (asynchronous, active-high)
//   level - debounced button level
//   press - one-cycle pulse on each rising edge of level
// A raw 0->1 held stable gives press exactly 2+DEB_CYCLES cycles after the
// first clock edge that samples the 1.
module roller_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            // Count consecutive cycles the synchronized value disagrees with
            // the accepted level; any agreement (bounce back) restarts it.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/roller_ctrl.sv
// roller_ctrl
// Sequences the 4-digit roller datapath: debounces the run/pause, clear and
// pattern-select buttons, runs the IDLE/RUN/PAUSE FSM, generates the roller
// step and position-clear pulses and drives the SSD anode scan.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   btn_run, btn_clr, btn_sel  - raw buttons (asynchronous, active-high)
//   step_en                    - one-cycle roller advance pulse
//   pos_clr                    - one-cycle roller position clear pulse
//   pattern_sel                - 1 = pattern A, 0 = pattern B
//   digit_idx, an              - scanned digit index and active-low anodes
//   running                    - high while in RUN
// Every output comes straight from a flop.
module roller_ctrl
    import roller_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int STEP_DIV   = 8,
    parameter int SCAN_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_run,
    input  logic                  btn_clr,
    input  logic                  btn_sel,
    output logic                  step_en,
    output logic                  pos_clr,
    output logic                  pattern_sel,
    output logic [1:0]            digit_idx,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  running
);

    localparam int SW  = $clog2(STEP_DIV);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Button order: 0 = run, 1 = clr, 2 = sel.
    logic [2:0] btn_raw;
    logic [2:0] btn_press;
    // Only the press edges drive the control; the held levels are not needed.
    logic [2:0] btn_level_unused;

    assign btn_raw = {btn_sel, btn_clr, btn_run};

    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
        roller_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[gi]),
            .level(btn_level_unused[gi]),
            .press(btn_press[gi])
        );
    end

    logic run_press;
    logic clr_press;
    logic sel_press;

    assign run_press = btn_press[0];
    assign clr_press = btn_press[1];
    assign sel_press = btn_press[2];

    state_t                state_q, state_d;
    logic [SW-1:0]         step_cnt_q, step_cnt_d;
    logic                  step_en_q, step_en_d;
    logic                  pos_clr_q, pos_clr_d;
    logic                  running_q, running_d;
    logic                  pattern_sel_q, pattern_sel_d;
    logic [SCW-1:0]        scan_cnt_q, scan_cnt_d;
    logic [1:0]            digit_idx_q, digit_idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    always_comb begin
        state_d       = state_q;
        pos_clr_d     = 1'b0;
        step_cnt_d    = step_cnt_q;
        step_en_d     = 1'b0;
        pattern_sel_d = pattern_sel_q ^ sel_press;
        scan_cnt_d    = scan_cnt_q + SCW'(1);
        digit_idx_d   = digit_idx_q;

        // Clear takes priority over run/pause in every state.
        case (state_q)
            ST_IDLE: begin
                if (clr_press) begin
                    pos_clr_d = 1'b1;
                end else if (run_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clr_press) begin
                    state_d   = ST_IDLE;
                    pos_clr_d = 1'b1;
                end else if (run_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clr_press) begin
                    state_d   = ST_IDLE;
                    pos_clr_d = 1'b1;
                end else if (run_press) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Prescaler only advances across cycles that stay in RUN, so the step
        // pulse can never appear alongside leaving RUN (pause or clear), and
        // PAUSE freezes the count for a mid-period resume.
        if (state_d == ST_IDLE) begin
            step_cnt_d = '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (step_cnt_q == SW'(STEP_DIV - 1)) begin
                step_cnt_d = '0;
                step_en_d  = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + SW'(1);
            end
        end

        running_d = (state_d == ST_RUN);

        if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end
        an_d = an_from_idx(digit_idx_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            step_cnt_q    <= '0;
            step_en_q     <= 1'b0;
            pos_clr_q     <= 1'b0;
            running_q     <= 1'b0;
            pattern_sel_q <= 1'b1;
            scan_cnt_q    <= '0;
            digit_idx_q   <= 2'd0;
            an_q          <= an_from_idx(2'd0);
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            step_en_q     <= step_en_d;
            pos_clr_q     <= pos_clr_d;
            running_q     <= running_d;
            pattern_sel_q <= pattern_sel_d;
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            an_q          <= an_d;
        end
    end

    assign step_en     = step_en_q;
    assign pos_clr     = pos_clr_q;
    assign running     = running_q;
    assign pattern_sel = pattern_sel_q;
    assign digit_idx   = digit_idx_q;
    assign an          = an_q;

endmodule

// File: tb/tb_roller_ctrl.sv
// tb_roller_ctrl
// Directed scenarios for roller_ctrl with default parameters. Expected
// step_en/pos_clr pulses (kind + clock-edge number) are queued when each
// scenario is issued; a monitor pops and compares whenever a pulse appears.
module tb_roller_ctrl;

    localparam int DEB  = 16;
    localparam int STEP = 8;
    localparam int SCAN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_run;
    logic       btn_clr;
    logic       btn_sel;
    logic       step_en;
    logic       pos_clr;
    logic       pattern_sel;
    logic [1:0] digit_idx;
    logic [3:0] an;
    logic       running;

    always #5 clk = ~clk;

    roller_ctrl #(
        .DEB_CYCLES(DEB),
        .STEP_DIV  (STEP),
        .SCAN_DIV  (SCAN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_run    (btn_run),
        .btn_clr    (btn_clr),
        .btn_sel    (btn_sel),
        .step_en    (step_en),
        .pos_clr    (pos_clr),
        .pattern_sel(pattern_sel),
        .digit_idx  (digit_idx),
        .an         (an),
        .running    (running)
    );

    // kind 0 = step_en, 1 = pos_clr; at = edge count after which it is seen
    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   chk_en = 1'b0;
    int   m_sc;
    logic [1:0] m_dig;

    // Rising-edge counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference for the anode scan: SCAN clocks per digit, restart on reset.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_sc  = 0;
            m_dig = 2'd0;
        end else if (m_sc == SCAN - 1) begin
            m_sc  = 0;
            m_dig = m_dig + 2'd1;
        end else begin
            m_sc++;
        end
    end

    // Monitor: scan check every cycle, pulse scoreboard on every pulse.
    initial begin
        ev_t        e;
        logic [3:0] an_exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                an_exp = 4'b0001 << m_dig;
                an_exp = ~an_exp;
                n_cmp++;
                if (digit_idx !== m_dig || an !== an_exp) begin
                    n_err++;
                    $display("FAIL scan cyc=%0d digit_idx=%0d an=%b expected digit_idx=%0d an=%b",
                             cyc, digit_idx, an, m_dig, an_exp);
                end
                while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_pulse cyc=%0d got none expected kind=%0d at=%0d",
                             cyc, e.kind, e.at);
                end
                if (step_en === 1'b1 || pos_clr === 1'b1) begin
                    n_cmp++;
                    if (step_en === 1'b1 && pos_clr === 1'b1) begin
                        n_err++;
                        $display("FAIL pulse_overlap cyc=%0d got step_en=1 pos_clr=1 expected at most one", cyc);
                        if (exp_q.size() > 0 && exp_q[0].at == cyc) void'(exp_q.pop_front());
                    end else if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_pulse cyc=%0d got step_en=%b pos_clr=%b expected none",
                                 cyc, step_en, pos_clr);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.at != cyc || e.kind != (pos_clr ? 1 : 0)) begin
                            n_err++;
                            $display("FAIL pulse cyc=%0d got kind=%0d expected kind=%0d at=%0d",
                                     cyc, pos_clr ? 1 : 0, e.kind, e.at);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, expv);
        end
    endtask

    // Return at the negedge where cyc == n (the next edge will be n+1).
    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_steps(input int first, input int last_edge);
        for (int t = first; t <= last_edge; t += STEP) exp_q.push_back('{0, t});
    endtask

    int t0, e0, p0, q0, s0, c0, u0, v0, w0;

    initial begin
        rst_n   = 1'b0;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        btn_sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_step_en", 32'(step_en), 32'd0);
        check("rst_pos_clr", 32'(pos_clr), 32'd0);
        check("rst_pattern_sel", 32'(pattern_sel), 32'd1);
        check("rst_digit_idx", 32'(digit_idx), 32'd0);
        check("rst_an", 32'(an), 32'hE);
        check("rst_running", 32'(running), 32'd0);

        // Idle: scan runs, nothing else moves.
        at_cyc(cyc + 20);
        check("idle_running", 32'(running), 32'd0);
        check("idle_pattern_sel", 32'(pattern_sel), 32'd1);

        // Bounced run press: 5 high, 2 low, then 20 high from edge e0.
        t0 = cyc + 2;
        e0 = t0 + 7;
        p0 = e0 + 60;
        push_steps(e0 + 27, p0 + 18);
        at_cyc(t0 - 1);
        btn_run = 1'b1;
        at_cyc(t0 + 4);
        btn_run = 1'b0;
        at_cyc(t0 + 6);
        btn_run = 1'b1;
        at_cyc(e0 + 18);
        check("run_before_press", 32'(running), 32'd0);
        at_cyc(e0 + 19);
        check("run_after_press", 32'(running), 32'd1);
        btn_run = 1'b0;

        // Pause: the prescaler freezes at 3.
        at_cyc(p0 - 1);
        btn_run = 1'b1;
        at_cyc(p0 + 18);
        check("pause_before", 32'(running), 32'd1);
        at_cyc(p0 + 19);
        check("pause_after", 32'(running), 32'd0);
        btn_run = 1'b0;

        // Resume: first step 5 cycles after running rises, then run+clr together.
        q0 = p0 + 80;
        s0 = q0 + 60;
        push_steps(q0 + 24, s0 + 18);
        exp_q.push_back('{1, s0 + 19});
        at_cyc(p0 + 50);
        check("pause_hold", 32'(running), 32'd0);
        at_cyc(q0 - 1);
        btn_run = 1'b1;
        at_cyc(q0 + 19);
        check("resume_running", 32'(running), 32'd1);
        btn_run = 1'b0;
        at_cyc(s0 - 1);
        btn_run = 1'b1;
        btn_clr = 1'b1;
        at_cyc(s0 + 19);
        check("clr_wins_running", 32'(running), 32'd0);
        btn_run = 1'b0;
        btn_clr = 1'b0;

        // Clear while already idle still pulses pos_clr.
        c0 = s0 + 60;
        exp_q.push_back('{1, c0 + 19});
        at_cyc(c0 - 1);
        btn_clr = 1'b1;
        at_cyc(c0 + 19);
        check("idle_clr_running", 32'(running), 32'd0);
        btn_clr = 1'b0;

        // Run, toggle pattern, then reset mid-run.
        u0 = c0 + 60;
        v0 = u0 + 40;
        w0 = v0 + 25;
        push_steps(u0 + 27, w0 - 1);
        at_cyc(u0 - 1);
        btn_run = 1'b1;
        at_cyc(u0 + 19);
        check("run2_running", 32'(running), 32'd1);
        btn_run = 1'b0;
        at_cyc(v0 - 1);
        btn_sel = 1'b1;
        at_cyc(v0 + 18);
        check("sel_before", 32'(pattern_sel), 32'd1);
        at_cyc(v0 + 19);
        check("sel_after", 32'(pattern_sel), 32'd0);
        btn_sel = 1'b0;
        at_cyc(w0 - 1);
        rst_n = 1'b0;
        at_cyc(w0);
        rst_n = 1'b1;
        check("rst2_pattern_sel", 32'(pattern_sel), 32'd1);
        check("rst2_running", 32'(running), 32'd0);
        check("rst2_an", 32'(an), 32'hE);
        check("rst2_pos_clr", 32'(pos_clr), 32'd0);
        check("rst2_step_en", 32'(step_en), 32'd0);

        at_cyc(w0 + 40);
        check("end_running", 32'(running), 32'd0);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
